// File: rtl/vga_render_arbiter.sv
// Four-way render arbiter for a shared character/register memory: combinational
// address-phase grant, registered data selection, conflict statistics per frame.
module vga_render_arbiter #(
  parameter int ROTATE = 0,
  parameter int CNT_W  = 16
) (
  input  logic             i_px_clk,
  input  logic             i_reset,
  input  logic             i_frame_start,
  input  logic [3:0]       i_req,
  input  logic [7:0]       i_addr0,
  input  logic [7:0]       i_addr1,
  input  logic [7:0]       i_addr2,
  input  logic [7:0]       i_addr3,
  input  logic [7:0]       i_dout0,
  input  logic [7:0]       i_dout1,
  input  logic [7:0]       i_dout2,
  input  logic [7:0]       i_dout3,
  input  logic [2:0]       i_color0,
  input  logic [2:0]       i_color1,
  input  logic [2:0]       i_color2,
  input  logic [2:0]       i_color3,
  input  logic [1:0]       i_zoom0,
  input  logic [1:0]       i_zoom1,
  input  logic [1:0]       i_zoom2,
  input  logic [1:0]       i_zoom3,
  input  logic             i_h2a0,
  input  logic             i_h2a1,
  input  logic             i_h2a2,
  input  logic             i_h2a3,
  output logic [7:0]       o_mem_addr,
  output logic [3:0]       o_gnt,
  output logic [7:0]       o_px_dout,
  output logic [2:0]       o_px_color,
  output logic [1:0]       o_px_zoom,
  output logic             o_px_h2a,
  output logic             o_px_valid,
  output logic [CNT_W-1:0] o_conflict_count
);

  logic [7:0]       w_addr  [4];
  logic [7:0]       w_dout  [4];
  logic [2:0]       w_color [4];
  logic [1:0]       w_zoom  [4];
  logic             w_h2a   [4];

  logic [1:0]       r_ptr;
  logic [3:0]       r_gnt_q;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_conflict_count;
  logic [7:0]       r_px_dout;
  logic [2:0]       r_px_color;
  logic [1:0]       r_px_zoom;
  logic             r_px_h2a;
  logic             r_px_valid;

  logic [3:0]       w_gnt;
  logic [7:0]       w_sel_dout;
  logic [2:0]       w_sel_color;
  logic [1:0]       w_sel_zoom;
  logic             w_sel_h2a;
  logic [2:0]       w_nreq;
  logic             w_conflict;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_addr  = '{i_addr0, i_addr1, i_addr2, i_addr3};
  assign w_dout  = '{i_dout0, i_dout1, i_dout2, i_dout3};
  assign w_color = '{i_color0, i_color1, i_color2, i_color3};
  assign w_zoom  = '{i_zoom0, i_zoom1, i_zoom2, i_zoom3};
  assign w_h2a   = '{i_h2a0, i_h2a1, i_h2a2, i_h2a3};

  // Search starts at r_ptr and walks upward modulo 4; first asserted request wins.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    w_gnt = 4'b0000;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = r_ptr + 2'(k);
      if (!found && i_req[idx]) begin
        w_gnt[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    o_mem_addr = 8'h00;
    for (int k = 0; k < 4; k++)
      if (w_gnt[k]) o_mem_addr = w_addr[k];
  end

  always_comb begin
    w_sel_dout  = 8'h00;
    w_sel_color = 3'b000;
    w_sel_zoom  = 2'b00;
    w_sel_h2a   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (r_gnt_q[k]) begin
        w_sel_dout  = w_dout[k];
        w_sel_color = w_color[k];
        w_sel_zoom  = w_zoom[k];
        w_sel_h2a   = w_h2a[k];
      end
    end
  end

  assign w_nreq     = {2'b00, i_req[0]} + {2'b00, i_req[1]} + {2'b00, i_req[2]} + {2'b00, i_req[3]};
  assign w_conflict = (w_nreq >= 3'd2);
  assign w_cnt_next = (w_conflict && !(&r_cnt)) ? r_cnt + CNT_W'(1) : r_cnt;

  always_ff @(posedge i_px_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr            <= 2'd0;
      r_gnt_q          <= 4'b0000;
      r_cnt            <= '0;
      r_conflict_count <= '0;
      r_px_dout        <= 8'h00;
      r_px_color       <= 3'b000;
      r_px_zoom        <= 2'b00;
      r_px_h2a         <= 1'b0;
      r_px_valid       <= 1'b0;
    end else begin
      if ((ROTATE != 0) && i_frame_start) r_ptr <= r_ptr + 2'd1;
      r_gnt_q    <= w_gnt;
      r_px_dout  <= w_sel_dout;
      r_px_color <= w_sel_color;
      r_px_zoom  <= w_sel_zoom;
      r_px_h2a   <= w_sel_h2a;
      r_px_valid <= |r_gnt_q;
      // The frame-start cycle's own conflict is folded into the reported count.
      if (i_frame_start) begin
        r_conflict_count <= w_cnt_next;
        r_cnt            <= '0;
      end else begin
        r_cnt <= w_cnt_next;
      end
    end
  end

  assign o_gnt            = w_gnt;
  assign o_px_dout        = r_px_dout;
  assign o_px_color       = r_px_color;
  assign o_px_zoom        = r_px_zoom;
  assign o_px_h2a         = r_px_h2a;
  assign o_px_valid       = r_px_valid;
  assign o_conflict_count = r_conflict_count;

endmodule

// File: tb/tb_vga_render_arbiter.sv
// Bench for vga_render_arbiter: fixed-priority, rotating and 4-bit-counter instances
// share one stimulus stream; pixel outputs are checked through a scoreboard queue.
module tb_vga_render_arbiter;

  typedef logic [14:0] px_t;  // {valid, dout, color, zoom, h2a}
  typedef struct packed {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [7:0] addr;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic [3:0] req;
  logic [7:0] addr  [4];
  logic [7:0] dout  [4];
  logic [2:0] color [4];
  logic [1:0] zoom  [4];
  logic       h2a   [4];

  logic [7:0]  mem_addr [3];
  logic [3:0]  gnt      [3];
  logic [7:0]  px_dout  [3];
  logic [2:0]  px_color [3];
  logic [1:0]  px_zoom  [3];
  logic        px_h2a   [3];
  logic        px_valid [3];
  logic [15:0] cc0, cc1;
  logic [3:0]  cc2;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  int  m_ptr1, m_cnt, m_cc16, m_cc4;
  logic [3:0] m_gq0, m_gq1;
  px_t q0[$];
  px_t q1[$];
  bit  force_d2 = 0;

  logic [3:0]  s_gnt0, s_gnt1;
  logic [7:0]  s_mem0;
  px_t         s_px0;
  logic [15:0] s_cc0;
  logic [3:0]  s_cc2;

  always #5 clk = ~clk;

  vga_render_arbiter #(.ROTATE(0), .CNT_W(16)) u_fix (
    .i_px_clk(clk), .i_reset(reset), .i_frame_start(frame_start), .i_req(req),
    .i_addr0(addr[0]), .i_addr1(addr[1]), .i_addr2(addr[2]), .i_addr3(addr[3]),
    .i_dout0(dout[0]), .i_dout1(dout[1]), .i_dout2(dout[2]), .i_dout3(dout[3]),
    .i_color0(color[0]), .i_color1(color[1]), .i_color2(color[2]), .i_color3(color[3]),
    .i_zoom0(zoom[0]), .i_zoom1(zoom[1]), .i_zoom2(zoom[2]), .i_zoom3(zoom[3]),
    .i_h2a0(h2a[0]), .i_h2a1(h2a[1]), .i_h2a2(h2a[2]), .i_h2a3(h2a[3]),
    .o_mem_addr(mem_addr[0]), .o_gnt(gnt[0]), .o_px_dout(px_dout[0]), .o_px_color(px_color[0]),
    .o_px_zoom(px_zoom[0]), .o_px_h2a(px_h2a[0]), .o_px_valid(px_valid[0]), .o_conflict_count(cc0));

  vga_render_arbiter #(.ROTATE(1), .CNT_W(16)) u_rot (
    .i_px_clk(clk), .i_reset(reset), .i_frame_start(frame_start), .i_req(req),
    .i_addr0(addr[0]), .i_addr1(addr[1]), .i_addr2(addr[2]), .i_addr3(addr[3]),
    .i_dout0(dout[0]), .i_dout1(dout[1]), .i_dout2(dout[2]), .i_dout3(dout[3]),
    .i_color0(color[0]), .i_color1(color[1]), .i_color2(color[2]), .i_color3(color[3]),
    .i_zoom0(zoom[0]), .i_zoom1(zoom[1]), .i_zoom2(zoom[2]), .i_zoom3(zoom[3]),
    .i_h2a0(h2a[0]), .i_h2a1(h2a[1]), .i_h2a2(h2a[2]), .i_h2a3(h2a[3]),
    .o_mem_addr(mem_addr[1]), .o_gnt(gnt[1]), .o_px_dout(px_dout[1]), .o_px_color(px_color[1]),
    .o_px_zoom(px_zoom[1]), .o_px_h2a(px_h2a[1]), .o_px_valid(px_valid[1]), .o_conflict_count(cc1));

  vga_render_arbiter #(.ROTATE(0), .CNT_W(4)) u_sat (
    .i_px_clk(clk), .i_reset(reset), .i_frame_start(frame_start), .i_req(req),
    .i_addr0(addr[0]), .i_addr1(addr[1]), .i_addr2(addr[2]), .i_addr3(addr[3]),
    .i_dout0(dout[0]), .i_dout1(dout[1]), .i_dout2(dout[2]), .i_dout3(dout[3]),
    .i_color0(color[0]), .i_color1(color[1]), .i_color2(color[2]), .i_color3(color[3]),
    .i_zoom0(zoom[0]), .i_zoom1(zoom[1]), .i_zoom2(zoom[2]), .i_zoom3(zoom[3]),
    .i_h2a0(h2a[0]), .i_h2a1(h2a[1]), .i_h2a2(h2a[2]), .i_h2a3(h2a[3]),
    .o_mem_addr(mem_addr[2]), .o_gnt(gnt[2]), .o_px_dout(px_dout[2]), .o_px_color(px_color[2]),
    .o_px_zoom(px_zoom[2]), .o_px_h2a(px_h2a[2]), .o_px_valid(px_valid[2]), .o_conflict_count(cc2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] model_gnt(input logic [3:0] rq, input int p);
    for (int k = 0; k < 4; k++)
      if (rq[(p + k) % 4]) return 4'b0001 << ((p + k) % 4);
    return 4'b0000;
  endfunction

  function automatic logic [7:0] addr_of(input logic [3:0] g);
    case (g)
      4'b0001: return 8'h11;
      4'b0010: return 8'h22;
      4'b0100: return 8'h3C;
      4'b1000: return 8'h44;
      default: return 8'h00;
    endcase
  endfunction

  function automatic px_t sel(input logic [3:0] g);
    for (int k = 0; k < 4; k++)
      if (g[k]) return {1'b1, dout[k], color[k], zoom[k], h2a[k]};
    return 15'd0;
  endfunction

  function automatic px_t px_of(input int d);
    return {px_valid[d], px_dout[d], px_color[d], px_zoom[d], px_h2a[d]};
  endfunction

  task automatic drive_data();
    for (int k = 0; k < 4; k++) begin
      dout[k]  = 8'(cyc * 8 + k + 1);
      color[k] = 3'(cyc + k);
      zoom[k]  = 2'(cyc + 3 * k);
      h2a[k]   = 1'((cyc >> 1) + k);
    end
    if (force_d2) dout[2] = 8'h0A;
  endtask

  task automatic model_reset();
    m_ptr1 = 0; m_cnt = 0; m_cc16 = 0; m_cc4 = 0;
    m_gq0 = 4'b0; m_gq1 = 4'b0;
    q0.delete(); q1.delete();
    q0.push_back(15'd0); q1.push_back(15'd0);
  endtask

  // Called at posedge+1; samples at posedge+5, then advances the model and the clock.
  task automatic cycle(input logic [3:0] rq, input logic fs);
    logic [3:0] g0, g1;
    px_t e0, e1;
    bit conf;
    req = rq; frame_start = fs;
    drive_data();
    g0 = model_gnt(rq, 0);
    g1 = model_gnt(rq, m_ptr1);
    #4;
    s_gnt0 = gnt[0]; s_gnt1 = gnt[1]; s_mem0 = mem_addr[0];
    s_px0 = px_of(0); s_cc0 = cc0; s_cc2 = cc2;
    chk("gnt_fix", gnt[0], g0);
    chk("mem_addr_fix", mem_addr[0], addr_of(g0));
    chk("gnt_rot", gnt[1], g1);
    chk("mem_addr_rot", mem_addr[1], addr_of(g1));
    chk("gnt_sat", gnt[2], g0);
    if (q0.size() == 0 || q1.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      chk("px_fix", px_of(0), e0);
      chk("px_rot", px_of(1), e1);
      chk("px_sat", px_of(2), e0);
    end
    chk("cc_fix", cc0, m_cc16);
    chk("cc_rot", cc1, m_cc16);
    chk("cc_sat", cc2, m_cc4);
    q0.push_back(sel(m_gq0));
    q1.push_back(sel(m_gq1));
    m_gq0 = g0; m_gq1 = g1;
    conf = ($countones(rq) >= 2);
    if (fs) begin
      m_cc16 = (m_cnt + conf > 65535) ? 65535 : m_cnt + conf;
      m_cc4  = (m_cnt + conf > 15) ? 15 : m_cnt + conf;
      m_cnt  = 0;
      m_ptr1 = (m_ptr1 + 1) % 4;
    end else if (conf) begin
      m_cnt++;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  vec_t vecs[8];
  logic [3:0] rot_exp[5];

  initial begin
    vecs[0] = '{req: 4'b0000, gnt: 4'b0000, addr: 8'h00};
    vecs[1] = '{req: 4'b0001, gnt: 4'b0001, addr: 8'h11};
    vecs[2] = '{req: 4'b0110, gnt: 4'b0010, addr: 8'h22};
    vecs[3] = '{req: 4'b1100, gnt: 4'b0100, addr: 8'h3C};
    vecs[4] = '{req: 4'b1000, gnt: 4'b1000, addr: 8'h44};
    vecs[5] = '{req: 4'b1111, gnt: 4'b0001, addr: 8'h11};
    vecs[6] = '{req: 4'b1010, gnt: 4'b0010, addr: 8'h22};
    vecs[7] = '{req: 4'b0100, gnt: 4'b0100, addr: 8'h3C};
    rot_exp[0] = 4'b0001; rot_exp[1] = 4'b0010; rot_exp[2] = 4'b0100;
    rot_exp[3] = 4'b1000; rot_exp[4] = 4'b0001;

    addr[0] = 8'h11; addr[1] = 8'h22; addr[2] = 8'h3C; addr[3] = 8'h44;
    reset = 1'b1; frame_start = 1'b0; req = 4'b0100;
    drive_data();
    #3;
    chk("rst_gnt_comb", gnt[0], 4'b0100);
    chk("rst_mem_addr_comb", mem_addr[0], 8'h3C);
    chk("rst_px", px_of(0), 15'd0);
    chk("rst_cc", cc0, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].req, 1'b0);
      chk("vec_gnt", s_gnt0, vecs[i].gnt);
      chk("vec_mem_addr", s_mem0, vecs[i].addr);
    end

    // Single requester: data two cycles after the request
    cycle(4'b0100, 1'b0);
    chk("single_gnt", s_gnt0, 4'b0100);
    chk("single_addr", s_mem0, 8'h3C);
    force_d2 = 1;
    cycle(4'b0000, 1'b0);
    force_d2 = 0;
    cycle(4'b0000, 1'b0);
    chk("single_px_dout", s_px0[13:6], 8'h0A);
    chk("single_px_valid", s_px0[14], 1'b1);

    // Fixed-priority conflict counting, without and with a conflict on frame_start
    cycle(4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1010, 1'b0);
      chk("conf_gnt", s_gnt0, 4'b0010);
    end
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b0);
    chk("conf_count5", s_cc0, 16'd5);
    for (int i = 0; i < 5; i++) cycle(4'b1010, 1'b0);
    cycle(4'b1010, 1'b1);
    cycle(4'b0000, 1'b0);
    chk("conf_count6", s_cc0, 16'd6);

    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) cycle(4'b1111, 1'b0);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b0);
    chk("sat_cc4", s_cc2, 4'hF);
    chk("sat_cc16", s_cc0, 16'd20);

    // Rotation: realign pointer to 0, then one frame per step
    for (int i = 0; i < 4 && m_ptr1 != 0; i++) cycle(4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 1'b0);
      chk("rot_gnt", s_gnt1, rot_exp[i]);
      cycle(4'b1111, 1'b1);
    end

    // Idle
    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b0);
    chk("idle_addr", s_mem0, 8'h00);
    chk("idle_px", s_px0, 15'd0);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) cycle(4'b0001, 1'b0);
    chk("pre_rst_valid", s_px0[14], 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", px_valid[0], 1'b0);
    chk("rst_mid_valid_rot", px_valid[1], 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc++;
    model_reset();
    cycle(4'b0001, 1'b0);
    chk("post_rst_valid0", s_px0[14], 1'b0);
    cycle(4'b0001, 1'b0);
    chk("post_rst_valid1", s_px0[14], 1'b0);
    cycle(4'b0001, 1'b0);
    chk("post_rst_valid2", s_px0[14], 1'b1);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/vga_render_arbiter.md
VGA_RENDER_ARBITER -- requirements
Module: vga_render_arbiter

Interface
REQ-001 Parameter ROTATE, default 0; 0 selects fixed priority (req[0] highest), 1 selects rotating priority advanced at each frame_start.
REQ-002 Parameter CNT_W, default 16; width of the conflict counter.
REQ-003 px_clk  input  1  pixel clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 frame_start  input  1  one-cycle pulse at the first pixel of each frame.
REQ-006 req  input  4  per-component "active" request for the current pixel.
REQ-007 addr0..addr3  input  8 each  requested memory address per component.
REQ-008 dout0..dout3  input  8 each  component render data, valid one cycle after its request.
REQ-009 color0..color3, zoom0..zoom3, h2a0..h2a3  input  3/2/1 each  component render attributes, valid one cycle after its request.
REQ-010 mem_addr  output  8  address to the shared character/register memory (1-cycle read latency).
REQ-011 gnt  output  4  one-hot address-phase grant (combinational).
REQ-012 px_dout, px_color, px_zoom, px_h2a  output  8/3/2/1  registered, arbitrated render outputs.
REQ-013 px_valid  output  1  registered; high when px_* carry a granted component's data.
REQ-014 conflict_count  output  CNT_W  conflict cycles in the previous frame.

Function
REQ-015 Address phase (cycle N): gnt SHALL have exactly one bit set for the highest-priority asserted req bit, and SHALL be all-zero when req == 0.
REQ-016 mem_addr SHALL equal addr of the granted component; when no grant, mem_addr = 8'h00.
REQ-017 Data phase (cycle N+1): the arbiter SHALL register gnt into gnt_q and select dout/color/zoom/h2a of the component indicated by gnt_q.
REQ-018 Output phase (cycle N+2): px_* and px_valid SHALL register the data-phase selection; total latency from req to px_* is 2 cycles.
REQ-019 When gnt_q == 0, the output phase SHALL load px_dout = 8'h00, px_color = BLACK (3'b000), px_zoom = 0, px_h2a = 0, px_valid = 0.
REQ-020 Priority pointer ptr (2 bits) SHALL define the highest-priority index; order is ptr, ptr+1, ptr+2, ptr+3 modulo 4.
REQ-021 ROTATE = 0: ptr SHALL remain 0 permanently.
REQ-022 ROTATE = 1: ptr SHALL increment by 1 (wrap 3 -> 0) on each cycle with frame_start = 1; the new ptr applies from the next cycle.
REQ-023 A conflict cycle is any cycle with two or more req bits set; the internal counter SHALL increment by 1 per conflict cycle and saturate at all-ones.
REQ-024 On frame_start, conflict_count SHALL load the internal count including the current cycle's conflict, if any; the internal counter SHALL clear to 0 in the same cycle.
REQ-025 Losing requesters SHALL receive no grant and no retry; their pixel is dropped.
REQ-026 Request changes between consecutive cycles SHALL need no idle cycle; back-to-back grants to different components SHALL be pipelined without bubbles.

Reset
REQ-027 While reset is high: ptr = 0, gnt_q = 0, internal counter = 0, conflict_count = 0, px_dout = 8'h00, px_color = 3'b000, px_zoom = 0, px_h2a = 0, px_valid = 0.
REQ-028 Reset asserted mid-pipeline SHALL immediately discard in-flight grants; the first valid px_* after release SHALL appear 2 cycles after the first sampled request.
REQ-029 gnt and mem_addr SHALL remain combinational functions of req, addr and ptr during reset.

Verification
REQ-030 Single requester: req = 4'b0100, addr2 = 8'h3C, dout2 = 8'h0A one cycle later -> gnt = 4'b0100, mem_addr = 8'h3C in the same cycle; px_dout = 8'h0A and px_valid = 1 two cycles after req.
REQ-031 Fixed-priority conflict (ROTATE = 0): req = 4'b1010 for 5 cycles, then frame_start -> gnt = 4'b0010 throughout; conflict_count = 5 after frame_start (6 if req is still 4'b1010 in the frame_start cycle).
REQ-032 Rotation (ROTATE = 1): req = 4'b1111 across 5 frame_start pulses -> gnt sequence 0001, 0010, 0100, 1000, 0001.
REQ-033 Idle: req = 0 -> mem_addr = 8'h00; px_valid = 0, px_color = 3'b000 after 2 cycles.
REQ-034 Saturation (CNT_W = 4): 20 conflict cycles, then frame_start -> conflict_count = 4'hF.
REQ-035 Reset mid-operation: req = 4'b0001 streaming; assert reset for 1 cycle -> px_valid = 0 immediately; px_valid returns to 1 two cycles after the first post-release request.
